// File: rtl/hx8352_bus_writer.sv
// hx8352_bus_writer: 8080-style 16-bit write master for the HX8352 TFT controller.
// Define HX8352_FIFO_EN to place a small input FIFO ahead of the strobe FSM.
module hx8352_bus_writer #(
    parameter int WR_LOW_CYC      = 2,
    parameter int WR_HIGH_CYC     = 2,
    parameter int RST_LOW_CYC     = 500000,
    parameter int RST_WAIT_CYC    = 2500000,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_rs,
    input  logic [15:0] in_data,
    output logic        init_done,
    output logic        busy,
    output logic [15:0] lcd_data,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic        lcd_cs_n,
    output logic        lcd_rst_n
);
    localparam int MAX_WR  = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int MAX_RST = (RST_LOW_CYC > RST_WAIT_CYC) ? RST_LOW_CYC : RST_WAIT_CYC;
    localparam int MAX_CYC = (MAX_WR > MAX_RST) ? MAX_WR : MAX_RST;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    typedef enum logic [2:0] {RST_LOW, RST_WAIT, IDLE, WR_LOW, WR_HIGH} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             slot;
    logic             take;
    logic [15:0]      word_data;
    logic             word_rs;

    // A new word may start in IDLE or in the final WR_HIGH cycle (back-to-back).
    assign slot = (state == IDLE) ||
                  ((state == WR_HIGH) && (cnt == CNT_W'(WR_HIGH_CYC - 1)));

`ifdef HX8352_FIFO_EN
    localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int FCW   = FIFO_DEPTH_LOG2 + 1;

    logic [15:0]                mem_data [DEPTH];
    logic                       mem_rs   [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FCW-1:0]             count;
    logic                       full, empty, push;

    assign full      = count[FIFO_DEPTH_LOG2];
    assign empty     = (count == '0);
    assign in_ready  = !full && !rst;
    assign push      = in_valid && in_ready;
    assign take      = slot && !empty;
    assign word_data = mem_data[rd_ptr];
    assign word_rs   = mem_rs[rd_ptr];
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (take) rd_ptr <= rd_ptr + 1'b1;
            count <= count + FCW'(push) - FCW'(take);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_rs[wr_ptr]   <= in_rs;
        end
    end
`else
    assign in_ready  = slot;
    assign take      = in_valid && slot;
    assign word_data = in_data;
    assign word_rs   = in_rs;
    assign busy      = (state != IDLE);
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        case (state)
            RST_LOW:
                if (cnt == CNT_W'(RST_LOW_CYC - 1)) begin
                    state_nx = RST_WAIT;
                    cnt_nx   = '0;
                end
            RST_WAIT:
                if (cnt == CNT_W'(RST_WAIT_CYC - 1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            IDLE: begin
                cnt_nx = '0;
                if (take) state_nx = WR_LOW;
            end
            WR_LOW:
                if (cnt == CNT_W'(WR_LOW_CYC - 1)) begin
                    state_nx = WR_HIGH;
                    cnt_nx   = '0;
                end
            WR_HIGH:
                if (cnt == CNT_W'(WR_HIGH_CYC - 1)) begin
                    state_nx = take ? WR_LOW : IDLE;
                    cnt_nx   = '0;
                end
            default: begin
                state_nx = RST_LOW;
                cnt_nx   = '0;
            end
        endcase
    end

    // Bus pins are registered from the next state so they leave the block glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_LOW;
            cnt       <= '0;
            init_done <= 1'b0;
            lcd_data  <= '0;
            lcd_rs    <= 1'b0;
            lcd_wr_n  <= 1'b1;
            lcd_cs_n  <= 1'b1;
            lcd_rst_n <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            lcd_wr_n  <= (state_nx != WR_LOW);
            lcd_cs_n  <= !((state_nx == WR_LOW) || (state_nx == WR_HIGH));
            lcd_rst_n <= (state_nx != RST_LOW);
            if (state_nx == IDLE) init_done <= 1'b1;
            if (take) begin
                lcd_data <= word_data;
                lcd_rs   <= word_rs;
            end
        end
    end

    assign lcd_rd_n = 1'b1;

endmodule

// File: tb/tb_hx8352_bus_writer.sv
// Randomized bench for hx8352_bus_writer: two instances (2/2 and 1/1 strobe timing)
// checked every cycle against a cycle-count reference model of the write protocol.
`timescale 1ns/1ps
module tb_hx8352_bus_writer;
    localparam int RL    = 4;
    localparam int RW    = 6;
    localparam int DEPTH = 4;
    localparam int NCYC  = 3000;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        in_valid, in_ready, in_rs;
    logic [1:0][15:0]  in_data, lcd_data;
    logic [1:0]        init_done, busy, lcd_rs, lcd_wr_n, lcd_rd_n, lcd_cs_n, lcd_rst_n;

    always #5 clk = ~clk;

    hx8352_bus_writer #(.WR_LOW_CYC(2), .WR_HIGH_CYC(2), .RST_LOW_CYC(RL),
                        .RST_WAIT_CYC(RW), .FIFO_DEPTH_LOG2(2)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_rs(in_rs[0]), .in_data(in_data[0]), .init_done(init_done[0]), .busy(busy[0]),
        .lcd_data(lcd_data[0]), .lcd_rs(lcd_rs[0]), .lcd_wr_n(lcd_wr_n[0]),
        .lcd_rd_n(lcd_rd_n[0]), .lcd_cs_n(lcd_cs_n[0]), .lcd_rst_n(lcd_rst_n[0]));

    hx8352_bus_writer #(.WR_LOW_CYC(1), .WR_HIGH_CYC(1), .RST_LOW_CYC(RL),
                        .RST_WAIT_CYC(RW), .FIFO_DEPTH_LOG2(2)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_rs(in_rs[1]), .in_data(in_data[1]), .init_done(init_done[1]), .busy(busy[1]),
        .lcd_data(lcd_data[1]), .lcd_rs(lcd_rs[1]), .lcd_wr_n(lcd_wr_n[1]),
        .lcd_rd_n(lcd_rd_n[1]), .lcd_cs_n(lcd_cs_n[1]), .lcd_rst_n(lcd_rst_n[1]));

    int checks = 0;
    int errors = 0;

    // Reference model: n counts cycles since rst was released.
    int          n;
    int          rdy_from [2];
    bit          act      [2];
    int          cstart   [2];
    logic [15:0] bus_d    [2];
    logic        bus_rs   [2];
`ifdef HX8352_FIFO_EN
    logic [16:0] fmem     [2][DEPTH];
    int          fcnt     [2];
`endif

    bit          src_v    [2];
    logic [15:0] src_d    [2];
    logic        src_rs   [2];
    bit          hs       [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d since rst release)",
                     tag, got, exp, n);
        end
    endtask

    function automatic int lo_cyc(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int hi_cyc(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    task automatic model_reset();
        n = 0;
        for (int i = 0; i < 2; i++) begin
            rdy_from[i] = RL + RW;
            act[i]      = 1'b0;
            cstart[i]   = 0;
            bus_d[i]    = 16'h0000;
            bus_rs[i]   = 1'b0;
`ifdef HX8352_FIFO_EN
            fcnt[i]     = 0;
`endif
        end
    endtask

    function automatic bit exp_ready(input int i);
`ifdef HX8352_FIFO_EN
        return !rst && (fcnt[i] < DEPTH);
`else
        return n >= rdy_from[i];
`endif
    endfunction

    task automatic start_word(input int i, input logic [16:0] w);
        act[i]      = 1'b1;
        cstart[i]   = n + 1;
        rdy_from[i] = n + lo_cyc(i) + hi_cyc(i);
        bus_d[i]    = w[15:0];
        bus_rs[i]   = w[16];
    endtask

    task automatic check_cycle(input int i);
        int p;
        bit a;
        bit eb;
        p  = lo_cyc(i) + hi_cyc(i);
        a  = act[i] && (n >= cstart[i]) && (n < cstart[i] + p);
        eb = (n < RL + RW) || a;
`ifdef HX8352_FIFO_EN
        eb = eb || (fcnt[i] != 0);
`endif
        chk($sformatf("u%0d.lcd_rst_n", i), 32'(lcd_rst_n[i]), 32'(n >= RL));
        chk($sformatf("u%0d.init_done", i), 32'(init_done[i]), 32'(n >= RL + RW));
        chk($sformatf("u%0d.lcd_cs_n", i),  32'(lcd_cs_n[i]),  32'(!a));
        chk($sformatf("u%0d.lcd_wr_n", i),  32'(lcd_wr_n[i]),  32'(!(a && (n < cstart[i] + lo_cyc(i)))));
        chk($sformatf("u%0d.lcd_rd_n", i),  32'(lcd_rd_n[i]),  32'(1));
        chk($sformatf("u%0d.lcd_data", i),  32'(lcd_data[i]),  32'(bus_d[i]));
        chk($sformatf("u%0d.lcd_rs", i),    32'(lcd_rs[i]),    32'(bus_rs[i]));
        chk($sformatf("u%0d.in_ready", i),  32'(in_ready[i]),  32'(exp_ready(i)));
        chk($sformatf("u%0d.busy", i),      32'(busy[i]),      32'(eb));
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
`ifdef HX8352_FIFO_EN
            int size0;
            size0 = fcnt[i];
            if ((fcnt[i] > 0) && (n >= rdy_from[i])) begin
                start_word(i, fmem[i][0]);
                for (int k = 0; k < DEPTH - 1; k++) fmem[i][k] = fmem[i][k+1];
                fcnt[i]--;
            end
            if (src_v[i] && (size0 < DEPTH)) begin
                fmem[i][fcnt[i]] = {src_rs[i], src_d[i]};
                fcnt[i]++;
            end
`else
            if (src_v[i] && (n >= rdy_from[i])) start_word(i, {src_rs[i], src_d[i]});
`endif
        end
        n++;
    endtask

    initial begin
        bit r;
        bit tgt_done;
        int prob;
        tgt_done = 1'b0;
        rst      = 1'b1;
        in_valid = '0;
        in_rs    = '0;
        in_data  = '0;
        for (int i = 0; i < 2; i++) begin
            src_v[i]  = 1'b0;
            src_d[i]  = 16'h0000;
            src_rs[i] = 1'b0;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            r = ((cyc % 900) >= 898);
            if (!tgt_done && (cyc > 1500) && act[0] && (n >= cstart[0]) &&
                (n < cstart[0] + lo_cyc(0))) begin
                r        = 1'b1;
                tgt_done = 1'b1;
            end
            rst = r;
            for (int i = 0; i < 2; i++) begin
                in_valid[i] = src_v[i];
                in_data[i]  = src_d[i];
                in_rs[i]    = src_rs[i];
            end
            #1;
            for (int i = 0; i < 2; i++) check_cycle(i);
            for (int i = 0; i < 2; i++) hs[i] = src_v[i] && exp_ready(i);
            model_step();
            case ((cyc / 150) % 3)
                0:       prob = 100;
                1:       prob = 60;
                default: prob = 20;
            endcase
            for (int i = 0; i < 2; i++) begin
                if (!src_v[i] || hs[i]) begin
                    src_v[i]  = ($urandom_range(0, 99) < prob);
                    src_d[i]  = 16'($urandom);
                    src_rs[i] = 1'($urandom);
                end
            end
            @(posedge clk);
            #1;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
